// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the scanning channel multiplexer:
//   state_t : controller states (IDLE / MANUAL / SCAN)
//   clog2   : ceiling log2 for elaboration-time width derivation
// ---------------------------------------------------------------------------
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Smallest r such that 2**r >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int k = 0; k < 31; k++) begin
            if (value > (32'sd1 <<< k)) begin
                result = k + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_scan_n_dwell_counter.sv
// ---------------------------------------------------------------------------
// dwell_counter
// Counts 0 .. DWELL-1 while enabled and flags the last cycle of each dwell.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   clr  : synchronous clear back to 0
//   en   : count enable
//   wrap : high during the cycle in which the count sits at DWELL-1 and
//          en is high; the counter returns to 0 on that edge
// ---------------------------------------------------------------------------
module dwell_counter
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int              CW       = clog2(DWELL + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);
    localparam logic [CW-1:0]   ONE_CNT  = CW'(1);
    localparam logic [CW-1:0]   ZERO_CNT = CW'(0);

    logic [CW-1:0] cnt_r;

    // wrap is a decode of the registered count so the parent can act on it
    // in the same cycle.
    assign wrap = en && (cnt_r == LAST_CNT);

    // Dwell count register: clear and wrap both return to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= ZERO_CNT;
        end else if (clr || wrap) begin
            cnt_r <= ZERO_CNT;
        end else if (en) begin
            cnt_r <= cnt_r + ONE_CNT;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// ---------------------------------------------------------------------------
// mux_scan_n
// N-channel multiplexer with manual select and automatic round-robin scan.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   i       : packed channel data, channel k at [k*W +: W]
//   s       : manual channel select (values >= N_CH are ignored)
//   mode    : 0 = manual, 1 = auto-scan
//   o       : registered data of the channel in ch
//   ch      : registered index of the channel driving o
//   o_valid : one-cycle pulse when ch changes, and on the first sample
//             after reset
// ---------------------------------------------------------------------------
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SW    = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] i,
    input  logic [SW-1:0]     s,
    input  logic              mode,
    output logic [W-1:0]      o,
    output logic [SW-1:0]     ch,
    output logic              o_valid
);

    // Width of a bit index into i.
    localparam int            IW      = clog2(N_CH * W);
    localparam logic [SW:0]   N_CH_L  = (SW + 1)'(N_CH);
    localparam logic [SW-1:0] LAST_CH = SW'(N_CH - 1);
    localparam logic [SW-1:0] ONE_CH  = SW'(1);
    localparam logic [SW-1:0] ZERO_CH = SW'(0);
    localparam logic [IW-1:0] W_L     = IW'(W);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [SW-1:0]   ch_r;
    logic [SW-1:0]   ch_nxt_s;
    logic [W-1:0]    o_r;
    logic [W-1:0]    o_nxt_s;
    logic            o_valid_r;
    logic            o_valid_nxt_s;
    logic [IW-1:0]   lsb_s;
    logic            s_ok_s;
    logic            cnt_en_s;
    logic            cnt_clr_s;
    logic            wrap_s;

    assign o       = o_r;
    assign ch      = ch_r;
    assign o_valid = o_valid_r;

    // Manual selects beyond the last channel (non-power-of-2 N_CH) are ignored.
    assign s_ok_s = ({1'b0, s} < N_CH_L);

    // Dwell only advances while scanning continues; any other cycle leaves
    // it at zero so a new scan starts with a full dwell.
    assign cnt_en_s  = (state_r == SCAN) && mode;
    assign cnt_clr_s = !cnt_en_s;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr_s),
        .en   (cnt_en_s),
        .wrap (wrap_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: mode is obeyed on every edge, with no intermediate state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, MANUAL, SCAN: begin
                if (mode) begin
                    state_nxt_s = SCAN;
                end else begin
                    state_nxt_s = MANUAL;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode: pick the next channel, then read o from that same
    // channel so o and ch always stay coherent.
    always_comb begin
        ch_nxt_s      = ch_r;
        o_valid_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                ch_nxt_s = ZERO_CH;
            end
            MANUAL, SCAN: begin
                if (!mode) begin
                    if (s_ok_s) begin
                        ch_nxt_s = s;
                    end else begin
                        ch_nxt_s = ch_r;
                    end
                end else if (wrap_s) begin
                    if (ch_r == LAST_CH) begin
                        ch_nxt_s = ZERO_CH;
                    end else begin
                        ch_nxt_s = ch_r + ONE_CH;
                    end
                end else begin
                    ch_nxt_s = ch_r;
                end
            end
            default: begin
                ch_nxt_s = ZERO_CH;
            end
        endcase

        if (state_r == IDLE) begin
            o_valid_nxt_s = 1'b1;
        end else begin
            o_valid_nxt_s = (ch_nxt_s != ch_r);
        end

        lsb_s   = IW'(ch_nxt_s) * W_L;
        o_nxt_s = {W{1'b0}};
        o_nxt_s = i[lsb_s +: W];
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_r      <= ZERO_CH;
            o_r       <= {W{1'b0}};
            o_valid_r <= 1'b0;
        end else begin
            ch_r      <= ch_nxt_s;
            o_r       <= o_nxt_s;
            o_valid_r <= o_valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_n
// Two instances: A (N_CH=4, W=8, DWELL=3) and B (N_CH=3, W=4, DWELL=1).
// Each edge is predicted by a behavioural model that tracks "how many
// cycles the current channel has been shown" rather than a dwell counter.
// ---------------------------------------------------------------------------
module tb_mux_scan_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] i_a;
    logic [1:0]  s_a;
    logic        mode_a;
    logic [7:0]  o_a;
    logic [1:0]  ch_a;
    logic        ov_a;

    logic [11:0] i_b;
    logic [1:0]  s_b;
    logic        mode_b;
    logic [3:0]  o_b;
    logic [1:0]  ch_b;
    logic        ov_b;

    int total = 0;
    int bad   = 0;

    mux_scan_n #(.N_CH(4), .W(8), .DWELL(3)) dut_a (
        .clk(clk), .rst(rst), .i(i_a), .s(s_a), .mode(mode_a),
        .o(o_a), .ch(ch_a), .o_valid(ov_a)
    );

    mux_scan_n #(.N_CH(3), .W(4), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .i(i_b), .s(s_b), .mode(mode_b),
        .o(o_b), .ch(ch_b), .o_valid(ov_b)
    );

    // Model parameters per instance.
    int m_n[2] = '{4, 3};
    int m_w[2] = '{8, 4};
    int m_d[2] = '{3, 1};

    // Model state: displayed channel, cycles shown so far in scan, outputs.
    int m_ch[2]      = '{0, 0};
    int m_age[2]     = '{0, 0};
    int m_o[2]       = '{0, 0};
    bit m_v[2]       = '{1'b0, 1'b0};
    bit m_started[2] = '{1'b0, 1'b0};
    bit m_scan[2]    = '{1'b0, 1'b0};

    task automatic model_step(input int d, input bit r, input bit md,
                              input int sel, input logic [31:0] data);
        int prev;
        if (r) begin
            m_ch[d] = 0; m_age[d] = 0; m_o[d] = 0;
            m_v[d] = 1'b0; m_started[d] = 1'b0; m_scan[d] = 1'b0;
        end else begin
            if (!m_started[d]) begin
                m_started[d] = 1'b1;
                m_ch[d]  = 0;
                m_age[d] = 1;
                m_v[d]   = 1'b1;
            end else begin
                prev = m_ch[d];
                if (md) begin
                    if (m_scan[d] && m_age[d] == m_d[d]) begin
                        m_ch[d]  = (m_ch[d] + 1) % m_n[d];
                        m_age[d] = 1;
                    end else if (m_scan[d]) begin
                        m_age[d] = m_age[d] + 1;
                    end else begin
                        m_age[d] = 1;
                    end
                end else begin
                    m_age[d] = 1;
                    if (sel < m_n[d]) m_ch[d] = sel;
                end
                m_v[d] = (m_ch[d] != prev);
            end
            m_scan[d] = md;
            m_o[d] = int'((data >> (m_ch[d] * m_w[d])) &
                          ((32'd1 << m_w[d]) - 32'd1));
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict both instances from the inputs present at the edge, then
    // compare shortly after the edge.
    task automatic step();
        model_step(0, rst, mode_a, int'(s_a), i_a);
        model_step(1, rst, mode_b, int'(s_b), {20'd0, i_b});
        @(posedge clk);
        #1;
        check("a.o",  32'(o_a),  32'(m_o[0]));
        check("a.ch", 32'(ch_a), 32'(m_ch[0]));
        check("a.ov", 32'(ov_a), 32'(m_v[0]));
        check("b.o",  32'(o_b),  32'(m_o[1]));
        check("b.ch", 32'(ch_b), 32'(m_ch[1]));
        check("b.ov", 32'(ov_b), 32'(m_v[1]));
    endtask

    logic [7:0] bytes_a [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int pulses_a;
    int pulses_b;

    initial begin
        rst = 1'b1; mode_a = 1'b0; s_a = 2'd2; i_a = 32'hDDCC_BBAA;
        mode_b = 1'b0; s_b = 2'd0; i_b = 12'h321;

        // Reset held three cycles.
        repeat (3) step();
        check("rst.o_a",  32'(o_a),  32'h0);
        check("rst.ch_a", 32'(ch_a), 32'h0);
        check("rst.ov_a", 32'(ov_a), 32'h0);

        // First edge after release samples channel 0, then s takes effect.
        rst = 1'b0;
        step();
        check("first.ch",  32'(ch_a), 32'h0);
        check("first.ov",  32'(ov_a), 32'h1);
        check("first.o",   32'(o_a),  32'hAA);
        step();
        check("second.ch", 32'(ch_a), 32'h2);
        check("second.o",  32'(o_a),  32'hCC);
        check("second.ov", 32'(ov_a), 32'h1);

        // Manual select walk with a held cycle after each change.
        for (int k = 0; k < 4; k++) begin
            s_a = 2'(k);
            step();
            check("man.o", 32'(o_a), 32'(bytes_a[k]));
            step();
            check("man.hold_ov", 32'(ov_a), 32'h0);
        end

        // Out-of-range manual select on the 3-channel instance.
        s_b = 2'd1;
        step();
        s_b = 2'd3;
        step();
        check("np2.ch", 32'(ch_b), 32'h1);
        check("np2.ov", 32'(ov_b), 32'h0);
        check("np2.o",  32'(o_b),  32'h2);

        // Scan: A pulses once per 3 cycles, B (DWELL=1) every cycle.
        mode_a = 1'b1; mode_b = 1'b1;
        step();
        pulses_a = 0; pulses_b = 0;
        repeat (12) begin
            step();
            pulses_a += int'(ov_a);
            pulses_b += int'(ov_b);
        end
        check("scan.pulses_a", 32'(pulses_a), 32'd4);
        check("scan.pulses_b", 32'(pulses_b), 32'd12);

        // Reach ch=2 one cycle into its dwell, then toggle mode.
        for (int k = 0; k < 20 && !(m_ch[0] == 2 && m_age[0] == 2); k++) step();
        check("sw.at2", 32'(ch_a), 32'h2);
        mode_a = 1'b0; s_a = 2'd0;
        step();
        check("sw.man0", 32'(ch_a), 32'h0);
        mode_a = 1'b1;
        repeat (3) begin
            step();
            check("sw.hold0", 32'(ch_a), 32'h0);
        end
        step();
        check("sw.adv1", 32'(ch_a), 32'h1);

        // Reset in the middle of a scan.
        rst = 1'b1;
        step();
        check("midrst.o_b",  32'(o_b),  32'h0);
        check("midrst.ch_b", 32'(ch_b), 32'h0);
        check("midrst.ov_b", 32'(ov_b), 32'h0);
        rst = 1'b0;
        step();
        check("midrst.restart_ov", 32'(ov_b), 32'h1);

        // Random traffic with occasional mode flips and resets.
        repeat (400) begin
            rst = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 11) == 0) mode_a = ~mode_a;
            if ($urandom_range(0, 11) == 0) mode_b = ~mode_b;
            if ($urandom_range(0, 3) == 0) s_a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) s_b = 2'($urandom_range(0, 3));
            i_a = $urandom();
            i_b = 12'($urandom());
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_n.md
MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 SHALL provide parameter N_CH, default 4: number of input channels, legal range 2..16.
REQ-002 SHALL provide parameter W, default 1: bits per channel, legal range 1..32.
REQ-003 SHALL provide parameter DWELL, default 4: cycles spent on each channel in scan mode, legal range 1..65535.
REQ-004 SHALL derive localparam SW = max(1, clog2(N_CH)): select width.
REQ-005 SHALL provide port: clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL provide port: rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL provide port: i  input  N_CH*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-008 SHALL provide port: s  input  SW  manual channel select.
REQ-009 SHALL provide port: mode  input  1  0 = manual, 1 = auto-scan.
REQ-010 SHALL provide port: o  output  W  registered selected channel data.
REQ-011 SHALL provide port: ch  output  SW  registered index of the channel currently driving o.
REQ-012 SHALL provide port: o_valid  output  1  one-cycle pulse when ch takes a new value, or on the first sample after reset.

Function
REQ-013 SHALL implement FSM states IDLE, MANUAL and SCAN.
REQ-014 SHALL move from IDLE on the first non-reset edge to MANUAL if mode=0, or to SCAN if mode=1; that edge samples channel 0 and pulses o_valid.
REQ-015 SHALL, in MANUAL, register ch <= s and o <= slice(s) on every edge; latency from s to o is 1 cycle.
REQ-016 SHALL, in MANUAL, hold ch and o's channel when s >= N_CH (non-power-of-2 N_CH), with o still refreshed from the held channel and no o_valid pulse.
REQ-017 SHALL, in SCAN, run dwell counter cnt from 0 to DWELL-1; at cnt=DWELL-1, advance ch by 1 (N_CH-1 wraps to 0) and clear cnt.
REQ-018 SHALL, in SCAN, update o every edge from the channel selected by the next-cycle value of ch, so that o and ch are always coherent.
REQ-019 SHALL, on a MANUAL->SCAN transition, start scanning from the current ch with cnt cleared.
REQ-020 SHALL, on a SCAN->MANUAL transition, load ch <= s on that same edge.
REQ-021 SHALL, in both modes, honour the mode input sampled at each edge, with no extra transition cycle.
REQ-022 SHALL assert o_valid for exactly one cycle whenever the registered ch value differs from its previous value, and never otherwise (apart from REQ-014).
REQ-023 SHALL, when DWELL=1, advance ch every cycle and hold o_valid continuously high while scanning.
REQ-024 SHALL use a counter of clog2(DWELL+1) bits that never exceeds DWELL-1.

Reset
REQ-025 SHALL, with rst=1 at an edge, set o=0, ch=0, o_valid=0, cnt=0 and state=IDLE.
REQ-026 SHALL let rst take priority over mode and s.
REQ-027 SHALL, on reset mid-scan, abandon the scan and resume from channel 0 through IDLE.

Structure
REQ-028 SHALL place the state enum (IDLE/MANUAL/SCAN) and a clog2 helper function in the shared package mux_scan_pkg.
REQ-029 SHALL implement the dwell counter as sub-module dwell_counter (params: DWELL; ports: clk, rst, clr, en, wrap pulse).
REQ-030 SHALL use no latches and build the output mux from an indexed part-select; the unconditioned default assignment of the combinational path is 0.

Verification
REQ-031 SHALL check reset: N_CH=4, W=1; hold rst 3 cycles, then release with mode=0, s=2, i=4'b0100 -> o=0, ch=0 during reset; one cycle after release ch=0 with o_valid pulse, next cycle ch=2, o=1 with o_valid pulse.
REQ-032 SHALL check manual select: W=8, i={8'hDD,8'hCC,8'hBB,8'hAA}; step s 0,1,2,3 -> one cycle later o = AA, BB, CC, DD, with one o_valid pulse per change; holding s -> no pulse.
REQ-033 SHALL check scan wrap: N_CH=4, DWELL=3, mode=1 -> ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; o_valid high on each change, 4 pulses per 12 cycles.
REQ-034 SHALL check mode switching: scanning at ch=2, cnt=1; set mode=0 with s=0 -> ch=0 next edge; return mode=1 -> ch stays 0 for DWELL cycles, then advances to 1.
REQ-035 SHALL check non-power-of-2: N_CH=3, manual, s=3 -> ch and o hold their previous channel, no o_valid; reset asserted mid-scan -> outputs 0 on that edge.
